// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   state_t          : controller FSM states
//   MUL_LATENCY_DEF  : default cycles a multiply occupies Execute
//   REG_ADDR_W_DEF   : default register index width
package pipeline_pkg;

   localparam int MUL_LATENCY_DEF = 4;
   localparam int REG_ADDR_W_DEF  = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_BUSY = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/pipeline_control_load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the load in Execute writes a register that the instruction in
// Decode actually reads. Register 0 is hardwired and never forms a hazard.
//   d_valid, d_rs1, d_rs2, d_uses_rs1, d_uses_rs2 : Decode-side sources
//   e_valid, e_is_load, e_rd                      : Execute-side load
//   hazard                                        : stall-one-cycle request
module load_use_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  d_valid,
   input  logic [REG_ADDR_W-1:0] d_rs1,
   input  logic [REG_ADDR_W-1:0] d_rs2,
   input  logic                  d_uses_rs1,
   input  logic                  d_uses_rs2,
   input  logic                  e_valid,
   input  logic                  e_is_load,
   input  logic [REG_ADDR_W-1:0] e_rd,
   output logic                  hazard
);

   logic rs1_hit, rs2_hit;

   assign rs1_hit = d_uses_rs1 && (d_rs1 == e_rd);
   assign rs2_hit = d_uses_rs2 && (d_rs2 == e_rd);
   assign hazard  = e_valid && e_is_load && (e_rd != '0) && d_valid &&
                    (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall / bubble / flush controller for a 5-stage in-order core.
// Handles, in priority order: data-cache miss, multi-cycle multiply,
// taken branch, load-use hazard.
//   clk, reset (async, active-high)
//   d_*      : Decode stage instruction info
//   e_*      : Execute stage instruction info
//   m_miss, m_mem_ready : Memory stage miss / refill return
//   fd_stall, de_stall, em_stall : hold the F/D, D/E, E/M registers
//   de_bubble, em_bubble         : load an invalid slot into D/E, E/M
//   flush                        : invalidate F/D and D/E
//   busy                         : controller not in RUN
module pipeline_control
   import pipeline_pkg::*;
#(
   parameter int MUL_LATENCY = MUL_LATENCY_DEF,
   parameter int REG_ADDR_W  = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  d_valid,
   input  logic [REG_ADDR_W-1:0] d_rs1,
   input  logic [REG_ADDR_W-1:0] d_rs2,
   input  logic                  d_uses_rs1,
   input  logic                  d_uses_rs2,
   input  logic                  e_valid,
   input  logic [REG_ADDR_W-1:0] e_rd,
   input  logic                  e_is_load,
   input  logic                  e_is_mul,
   input  logic                  e_branch_taken,
   input  logic                  m_miss,
   input  logic                  m_mem_ready,
   output logic                  fd_stall,
   output logic                  de_stall,
   output logic                  em_stall,
   output logic                  de_bubble,
   output logic                  em_bubble,
   output logic                  flush,
   output logic                  busy
);

   localparam int CW = $clog2(MUL_LATENCY) + 1;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          hazard;
   logic          taken;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
      .d_valid    (d_valid),
      .d_rs1      (d_rs1),
      .d_rs2      (d_rs2),
      .d_uses_rs1 (d_uses_rs1),
      .d_uses_rs2 (d_uses_rs2),
      .e_valid    (e_valid),
      .e_is_load  (e_is_load),
      .e_rd       (e_rd),
      .hazard     (hazard)
   );

   assign taken = e_valid && e_branch_taken;
   assign busy  = (state != RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      fd_stall  = 1'b0;
      de_stall  = 1'b0;
      em_stall  = 1'b0;
      de_bubble = 1'b0;
      em_bubble = 1'b0;
      flush     = 1'b0;
      case (state)
         RUN: begin
            if (m_miss) begin
               // cnt is left alone; it is 0 here, so the refill returns to RUN
               // and a pending multiply starts its sequence afterwards
               fd_stall = 1'b1;
               de_stall = 1'b1;
               em_stall = 1'b1;
               state_n  = MEM_WAIT;
            end else if (e_valid && e_is_mul) begin
               fd_stall  = 1'b1;
               de_stall  = 1'b1;
               em_bubble = 1'b1;
               cnt_n     = CW'(MUL_LATENCY - 1);
               state_n   = MUL_BUSY;
            end else if (taken) begin
               // flush also covers the load-use case: no de_bubble needed
               flush = 1'b1;
            end else if (hazard) begin
               fd_stall  = 1'b1;
               de_bubble = 1'b1;
            end
         end
         MUL_BUSY: begin
            if (m_miss) begin
               // cnt frozen so the multiply resumes where it left off
               fd_stall = 1'b1;
               de_stall = 1'b1;
               em_stall = 1'b1;
               state_n  = MEM_WAIT;
            end else if (cnt > CW'(1)) begin
               fd_stall  = 1'b1;
               de_stall  = 1'b1;
               em_bubble = 1'b1;
               cnt_n     = cnt - CW'(1);
            end else begin
               // final multiply cycle: result advances, pipeline released
               flush   = taken;
               cnt_n   = '0;
               state_n = RUN;
            end
         end
         MEM_WAIT: begin
            if (!m_mem_ready) begin
               fd_stall = 1'b1;
               de_stall = 1'b1;
               em_stall = 1'b1;
            end else begin
               // ready beats any coincident miss; that miss is seen next state
               flush   = taken;
               state_n = (cnt != '0) ? MUL_BUSY : RUN;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control (MUL_LATENCY=4, REG_ADDR_W=5).
// Expected output word order: {fd_stall, de_stall, em_stall, de_bubble,
// em_bubble, flush, busy}.
module tb_pipeline_control;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid;
   logic [4:0] d_rs1, d_rs2;
   logic       d_uses_rs1, d_uses_rs2;
   logic       e_valid;
   logic [4:0] e_rd;
   logic       e_is_load, e_is_mul, e_branch_taken;
   logic       m_miss, m_mem_ready;
   logic       fd_stall, de_stall, em_stall, de_bubble, em_bubble, flush, busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipeline_control #(.MUL_LATENCY(4), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .d_valid        (d_valid),
      .d_rs1          (d_rs1),
      .d_rs2          (d_rs2),
      .d_uses_rs1     (d_uses_rs1),
      .d_uses_rs2     (d_uses_rs2),
      .e_valid        (e_valid),
      .e_rd           (e_rd),
      .e_is_load      (e_is_load),
      .e_is_mul       (e_is_mul),
      .e_branch_taken (e_branch_taken),
      .m_miss         (m_miss),
      .m_mem_ready    (m_mem_ready),
      .fd_stall       (fd_stall),
      .de_stall       (de_stall),
      .em_stall       (em_stall),
      .de_bubble      (de_bubble),
      .em_bubble      (em_bubble),
      .flush          (flush),
      .busy           (busy)
   );

   logic [6:0] got;
   assign got = {fd_stall, de_stall, em_stall, de_bubble, em_bubble, flush, busy};

   typedef struct {
      string      name;
      logic       dv;
      logic [4:0] rs1, rs2;
      logic       u1, u2, ev;
      logic [4:0] rd;
      logic       ld, br;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [6:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // sample mid-cycle, then advance to just after the next rising edge
   task automatic cyc(input string name, input logic [6:0] exp);
      @(negedge clk);
      check(name, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_uses_rs1 = 0; d_uses_rs2 = 0;
      e_valid = 0; e_rd = 0; e_is_load = 0; e_is_mul = 0; e_branch_taken = 0;
      m_miss = 0; m_mem_ready = 0;
   endtask

   initial begin
      //           name          dv rs1 rs2 u1 u2 ev rd  ld br  exp
      vecs[0]  = '{"idle",        0, 0,  0,  0, 0, 0, 0,  0, 0, 7'b0000000};
      vecs[1]  = '{"lu_rs1",      1, 5,  0,  1, 0, 1, 5,  1, 0, 7'b1001000};
      vecs[2]  = '{"lu_rd0",      1, 0,  0,  1, 0, 1, 0,  1, 0, 7'b0000000};
      vecs[3]  = '{"lu_rs2",      1, 1,  9,  0, 1, 1, 9,  1, 0, 7'b1001000};
      vecs[4]  = '{"lu_rs2_unused",1,1,  9,  0, 0, 1, 9,  1, 0, 7'b0000000};
      vecs[5]  = '{"lu_dinvalid", 0, 5,  0,  1, 0, 1, 5,  1, 0, 7'b0000000};
      vecs[6]  = '{"lu_einvalid", 1, 5,  0,  1, 0, 0, 5,  1, 0, 7'b0000000};
      vecs[7]  = '{"lu_notload",  1, 5,  0,  1, 0, 1, 5,  0, 0, 7'b0000000};
      vecs[8]  = '{"branch",      0, 0,  0,  0, 0, 1, 0,  0, 1, 7'b0000010};
      vecs[9]  = '{"branch_lu",   1, 5,  0,  1, 0, 1, 5,  1, 1, 7'b0000010};
      vecs[10] = '{"lu_mismatch", 1, 6,  5,  1, 0, 1, 5,  1, 0, 7'b0000000};
      vecs[11] = '{"branch_einv", 0, 0,  0,  0, 0, 0, 0,  0, 1, 7'b0000000};

      idle();
      reset = 1;
      #2;
      check("reset", 7'b0000000);
      @(posedge clk); #1;
      reset = 0;

      for (int i = 0; i < 12; i++) begin
         d_valid = vecs[i].dv; d_rs1 = vecs[i].rs1; d_rs2 = vecs[i].rs2;
         d_uses_rs1 = vecs[i].u1; d_uses_rs2 = vecs[i].u2;
         e_valid = vecs[i].ev; e_rd = vecs[i].rd;
         e_is_load = vecs[i].ld; e_branch_taken = vecs[i].br;
         cyc(vecs[i].name, vecs[i].exp);
      end
      idle();

      // multiply: 3 stall cycles, released in the 4th, busy cycles 2-4
      e_valid = 1; e_is_mul = 1;
      cyc("mul_c1", 7'b1100100);
      e_is_mul = 0;
      cyc("mul_c2", 7'b1100101);
      cyc("mul_c3", 7'b1100101);
      cyc("mul_c4", 7'b0000001);
      cyc("mul_done", 7'b0000000);
      idle();

      // miss in RUN, ready arrives on the 7th cycle
      m_miss = 1;
      cyc("miss_c1", 7'b1110000);
      for (int k = 2; k <= 6; k++) cyc($sformatf("miss_c%0d", k), 7'b1110001);
      m_miss = 0; m_mem_ready = 1;
      cyc("miss_ready", 7'b0000001);
      m_mem_ready = 0;
      cyc("miss_run", 7'b0000000);

      // miss while multiply has cnt=2: cnt held, resume with 1 stall cycle
      e_valid = 1; e_is_mul = 1;
      cyc("mm_c1", 7'b1100100);
      e_is_mul = 0;
      cyc("mm_cnt3", 7'b1100101);
      m_miss = 1;
      cyc("mm_miss", 7'b1110001);
      cyc("mm_wait1", 7'b1110001);
      cyc("mm_wait2", 7'b1110001);
      m_miss = 0; m_mem_ready = 1;
      cyc("mm_ready", 7'b0000001);
      m_mem_ready = 0;
      cyc("mm_resume", 7'b1100101);
      cyc("mm_release", 7'b0000001);
      cyc("mm_run", 7'b0000000);
      idle();

      // miss and multiply together: refill first, then multiply sequence
      e_valid = 1; e_is_mul = 1; m_miss = 1;
      cyc("mx_miss", 7'b1110000);
      m_miss = 0; m_mem_ready = 1;
      cyc("mx_ready", 7'b0000001);
      m_mem_ready = 0;
      cyc("mx_mul", 7'b1100100);
      e_is_mul = 0;
      cyc("mx_b1", 7'b1100101);
      cyc("mx_b2", 7'b1100101);
      cyc("mx_rel", 7'b0000001);
      idle();

      // ready and a new miss together: ready wins, miss taken in RUN next
      m_miss = 1;
      cyc("rm_miss", 7'b1110000);
      m_mem_ready = 1;
      cyc("rm_ready", 7'b0000001);
      m_mem_ready = 0;
      cyc("rm_newmiss", 7'b1110000);
      m_miss = 0;
      cyc("rm_wait", 7'b1110001);
      m_mem_ready = 1;
      cyc("rm_ready2", 7'b0000001);
      idle();

      // taken branch during MEM_WAIT: flush only in ready cycle
      m_miss = 1; e_valid = 1; e_branch_taken = 1;
      cyc("bw_miss", 7'b1110000);
      m_miss = 0;
      cyc("bw_wait", 7'b1110001);
      m_mem_ready = 1;
      cyc("bw_ready", 7'b0000011);
      idle();
      cyc("bw_run", 7'b0000000);

      // reset mid multiply at cnt=3
      e_valid = 1; e_is_mul = 1;
      cyc("rs_mul", 7'b1100100);
      idle();
      #2;
      check("rs_pre", 7'b1100101);
      reset = 1;
      #1;
      check("rs_async", 7'b0000000);
      @(posedge clk); #1;
      reset = 0;
      cyc("rs_after", 7'b0000000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
